// File: rtl/fifo_lsu_gen_if.sv
// Handshake/data bundle between LSU issue and the request FIFO.
// master drives requests, slave is the FIFO.
interface fifo_lsu_gen_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             Wable;
  logic [WIDTH-1:0] Din;
  logic             Rable;
  logic [WIDTH-1:0] Dout;
  logic             DoutValid;
  logic [WIDTH-1:0] FifoPreOut;
  logic             FifoClean;
  logic             Squash;
  logic [AW:0]      SquashNum;
  logic [AW:0]      Count;
  logic             FifoFull;
  logic             FifoEmpty;
  logic             AlmostFull;
  logic             OvfErr;
  logic             UdfErr;

  modport master (
    output Wable, Din, Rable, FifoClean,
    output Squash, SquashNum,
    input  Dout, DoutValid, FifoPreOut,
    input  Count, FifoFull, FifoEmpty,
    input  AlmostFull, OvfErr, UdfErr
  );

  modport slave (
    input  Wable, Din, Rable, FifoClean,
    input  Squash, SquashNum,
    output Dout, DoutValid, FifoPreOut,
    output Count, FifoFull, FifoEmpty,
    output AlmostFull, OvfErr, UdfErr
  );
endinterface

// File: rtl/fifo_lsu_gen.sv
// LSU request FIFO: power-of-two depth, tail squash, flush,
// registered pop port plus combinational head peek.
module fifo_lsu_gen #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = DEPTH - 2
) (
  input logic           Clk,
  input logic           Rest,
  fifo_lsu_gen_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_AFTH = (AW+1)'(AFULL_TH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_ovf;
  logic             r_udf;

  logic [AW:0] w_count;
  logic        w_full;
  logic        w_empty;
  logic        w_rd_acc;
  logic        w_wr_acc;
  logic [AW:0] w_rd_inc;
  logic [AW:0] w_rd_next;
  logic [AW:0] w_cprime;
  logic [AW:0] w_kill;

  // MSB differs with equal index bits means wrapped once: full
  assign w_count  = r_wr_ptr - r_rd_ptr;
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_rd_acc  = bus.Rable && !w_empty;
  assign w_wr_acc  = bus.Wable && !bus.Squash &&
                     !bus.FifoClean && (!w_full || w_rd_acc);
  assign w_rd_inc  = {{AW{1'b0}}, w_rd_acc};
  assign w_rd_next = r_rd_ptr + w_rd_inc;

  // Squash never reaches past entries still resident after the pop
  assign w_cprime = w_count - w_rd_inc;
  assign w_kill   = (bus.SquashNum < w_cprime) ?
                    bus.SquashNum : w_cprime;

  always_ff @(posedge Clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[AW-1:0]] <= bus.Din;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rest) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_ovf        <= 1'b0;
      r_udf        <= 1'b0;
    end else begin
      r_rd_ptr     <= w_rd_next;
      r_dout_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_dout <= r_mem[r_rd_ptr[AW-1:0]];
      end
      if (bus.FifoClean) begin
        r_wr_ptr <= w_rd_next;
        r_ovf    <= 1'b0;
        r_udf    <= 1'b0;
      end else begin
        if (bus.Squash) begin
          r_wr_ptr <= r_wr_ptr - w_kill;
        end else if (w_wr_acc) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (bus.Wable && !w_wr_acc && !bus.Squash) begin
          r_ovf <= 1'b1;
        end
        if (bus.Rable && w_empty) begin
          r_udf <= 1'b1;
        end
      end
    end
  end

  assign bus.Dout       = r_dout;
  assign bus.DoutValid  = r_dout_valid;
  assign bus.FifoPreOut = r_mem[r_rd_ptr[AW-1:0]];
  assign bus.Count      = w_count;
  assign bus.FifoFull   = w_full;
  assign bus.FifoEmpty  = w_empty;
  assign bus.AlmostFull = (w_count >= LP_AFTH);
  assign bus.OvfErr     = r_ovf;
  assign bus.UdfErr     = r_udf;
endmodule

// File: tb/tb_fifo_lsu_gen.sv
// Directed bench for fifo_lsu_gen at WIDTH=16, DEPTH=8, AFULL_TH=6.
// Each task drives one scenario and checks against hand-computed values.
module tb_fifo_lsu_gen;
  localparam int W  = 16;
  localparam int D  = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchk = 0;
  int   nerr = 0;

  fifo_lsu_gen_if #(.WIDTH(W), .DEPTH(D)) bus ();

  fifo_lsu_gen #(
    .WIDTH(W), .DEPTH(D), .AFULL_TH(6)
  ) dut (
    .Clk (clk),
    .Rest(rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.Wable     = 1'b0;
    bus.Din       = '0;
    bus.Rable     = 1'b0;
    bus.FifoClean = 1'b0;
    bus.Squash    = 1'b0;
    bus.SquashNum = '0;
  endtask

  task automatic push(input logic [W-1:0] v);
    bus.Wable = 1'b1;
    bus.Din   = v;
    step();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    nchk++;
    if (bus.Count !== 4'd0 || bus.FifoEmpty !== 1'b1 ||
        bus.FifoFull !== 1'b0 || bus.AlmostFull !== 1'b0) begin
      nerr++;
      $display("FAIL reset_status: count=%0d e=%b f=%b af=%b want 0 1 0 0",
               bus.Count, bus.FifoEmpty, bus.FifoFull, bus.AlmostFull);
    end
    nchk++;
    if (bus.Dout !== 16'h0 || bus.DoutValid !== 1'b0 ||
        bus.OvfErr !== 1'b0 || bus.UdfErr !== 1'b0) begin
      nerr++;
      $display("FAIL reset_out: dout=%h dv=%b ovf=%b udf=%b want 0 0 0 0",
               bus.Dout, bus.DoutValid, bus.OvfErr, bus.UdfErr);
    end
  endtask

  task automatic test_fill_ovf();
    for (int i = 1; i <= 8; i++) begin
      push(W'(i));
      nchk++;
      if (bus.Count !== 4'(i) || bus.AlmostFull !== (i >= 6)) begin
        nerr++;
        $display("FAIL fill_%0d: count=%0d af=%b want %0d %b",
                 i, bus.Count, bus.AlmostFull, i, (i >= 6));
      end
    end
    nchk++;
    if (bus.FifoFull !== 1'b1 || bus.FifoPreOut !== 16'h0001) begin
      nerr++;
      $display("FAIL full_flag: full=%b pre=%h want 1 0001",
               bus.FifoFull, bus.FifoPreOut);
    end
    push(16'hDEAD);
    nchk++;
    if (bus.OvfErr !== 1'b1 || bus.Count !== 4'd8) begin
      nerr++;
      $display("FAIL ovf: ovf=%b count=%0d want 1 8",
               bus.OvfErr, bus.Count);
    end
  endtask

  task automatic test_push_pop_full();
    bus.Wable = 1'b1;
    bus.Din   = 16'h0009;
    bus.Rable = 1'b1;
    step();
    idle();
    nchk++;
    if (bus.Dout !== 16'h0001 || bus.DoutValid !== 1'b1 ||
        bus.Count !== 4'd8) begin
      nerr++;
      $display("FAIL full_pushpop: dout=%h dv=%b count=%0d want 0001 1 8",
               bus.Dout, bus.DoutValid, bus.Count);
    end
    for (int i = 0; i < 8; i++) begin
      nchk++;
      if (bus.FifoPreOut !== W'(i + 2)) begin
        nerr++;
        $display("FAIL drain_pre_%0d: pre=%h want %h",
                 i, bus.FifoPreOut, W'(i + 2));
      end
      bus.Rable = 1'b1;
      step();
      idle();
      nchk++;
      if (bus.Dout !== W'(i + 2) || bus.DoutValid !== 1'b1) begin
        nerr++;
        $display("FAIL drain_%0d: dout=%h dv=%b want %h 1",
                 i, bus.Dout, bus.DoutValid, W'(i + 2));
      end
    end
    nchk++;
    if (bus.FifoEmpty !== 1'b1 || bus.Count !== 4'd0 ||
        bus.OvfErr !== 1'b1) begin
      nerr++;
      $display("FAIL drained: e=%b count=%0d ovf=%b want 1 0 1",
               bus.FifoEmpty, bus.Count, bus.OvfErr);
    end
  endtask

  task automatic test_underflow_clean();
    bus.Rable = 1'b1;
    step();
    idle();
    nchk++;
    if (bus.UdfErr !== 1'b1 || bus.DoutValid !== 1'b0 ||
        bus.Dout !== 16'h0009) begin
      nerr++;
      $display("FAIL udf: udf=%b dv=%b dout=%h want 1 0 0009",
               bus.UdfErr, bus.DoutValid, bus.Dout);
    end
    bus.FifoClean = 1'b1;
    step();
    idle();
    nchk++;
    if (bus.UdfErr !== 1'b0 || bus.OvfErr !== 1'b0 ||
        bus.Count !== 4'd0) begin
      nerr++;
      $display("FAIL clean_err: udf=%b ovf=%b count=%0d want 0 0 0",
               bus.UdfErr, bus.OvfErr, bus.Count);
    end
  endtask

  task automatic test_squash();
    for (int i = 0; i < 5; i++) push(W'(16'h00A0 + i));
    bus.Squash    = 1'b1;
    bus.SquashNum = 4'd2;
    bus.Wable     = 1'b1;
    bus.Din       = 16'h00FF;
    step();
    idle();
    nchk++;
    if (bus.Count !== 4'd3 || bus.OvfErr !== 1'b0) begin
      nerr++;
      $display("FAIL squash2: count=%0d ovf=%b want 3 0",
               bus.Count, bus.OvfErr);
    end
    for (int i = 0; i < 3; i++) begin
      bus.Rable = 1'b1;
      step();
      idle();
      nchk++;
      if (bus.Dout !== W'(16'h00A0 + i) || bus.DoutValid !== 1'b1) begin
        nerr++;
        $display("FAIL squash_pop_%0d: dout=%h dv=%b want %h 1",
                 i, bus.Dout, bus.DoutValid, W'(16'h00A0 + i));
      end
    end
    for (int i = 0; i < 3; i++) push(W'(16'h0010 + i));
    bus.Squash    = 1'b1;
    bus.SquashNum = 4'd7;
    step();
    idle();
    nchk++;
    if (bus.Count !== 4'd0 || bus.FifoEmpty !== 1'b1) begin
      nerr++;
      $display("FAIL squash7: count=%0d e=%b want 0 1",
               bus.Count, bus.FifoEmpty);
    end
    // pop and over-sized squash together: pop still returns the head
    for (int i = 0; i < 3; i++) push(W'(16'h0020 + i));
    bus.Squash    = 1'b1;
    bus.SquashNum = 4'd7;
    bus.Rable     = 1'b1;
    step();
    idle();
    nchk++;
    if (bus.Dout !== 16'h0020 || bus.DoutValid !== 1'b1 ||
        bus.Count !== 4'd0) begin
      nerr++;
      $display("FAIL squash_pop: dout=%h dv=%b count=%0d want 0020 1 0",
               bus.Dout, bus.DoutValid, bus.Count);
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] q[$];
    logic [W-1:0] exp;
    logic [W-1:0] v;
    for (int i = 0; i < 3; i++) begin
      v = W'(16'h0100 + i);
      push(v);
      q.push_back(v);
    end
    for (int i = 0; i < 20; i++) begin
      nchk++;
      if (bus.FifoPreOut !== q[0]) begin
        nerr++;
        $display("FAIL wrap_pre_%0d: pre=%h want %h",
                 i, bus.FifoPreOut, q[0]);
      end
      v = W'(16'h0200 + i);
      bus.Wable = 1'b1;
      bus.Din   = v;
      bus.Rable = 1'b1;
      q.push_back(v);
      exp = q.pop_front();
      step();
      idle();
      nchk++;
      if (bus.Dout !== exp || bus.Count !== 4'd3) begin
        nerr++;
        $display("FAIL wrap_%0d: dout=%h count=%0d want %h 3",
                 i, bus.Dout, bus.Count, exp);
      end
    end
    push(16'h0300);
    nchk++;
    if (bus.Count !== 4'd4) begin
      nerr++;
      $display("FAIL wrap_count4: count=%0d want 4", bus.Count);
    end
    bus.Rable     = 1'b1;
    bus.Wable     = 1'b1;
    bus.Din       = 16'h0BAD;
    bus.FifoClean = 1'b1;
    step();
    idle();
    nchk++;
    if (bus.Dout !== q[0] || bus.DoutValid !== 1'b1 ||
        bus.Count !== 4'd0) begin
      nerr++;
      $display("FAIL clean_pop: dout=%h dv=%b count=%0d want %h 1 0",
               bus.Dout, bus.DoutValid, bus.Count, q[0]);
    end
  endtask

  task automatic test_reset_mid();
    push(16'h0041);
    push(16'h0042);
    bus.Rable = 1'b1;
    bus.Wable = 1'b1;
    bus.Din   = 16'h0043;
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    nchk++;
    if (bus.Count !== 4'd0 || bus.Dout !== 16'h0 ||
        bus.DoutValid !== 1'b0 || bus.FifoEmpty !== 1'b1) begin
      nerr++;
      $display("FAIL reset_mid: count=%0d dout=%h dv=%b e=%b want 0 0 0 1",
               bus.Count, bus.Dout, bus.DoutValid, bus.FifoEmpty);
    end
    push(16'h0055);
    nchk++;
    if (bus.FifoPreOut !== 16'h0055 || bus.Count !== 4'd1) begin
      nerr++;
      $display("FAIL reset_head: pre=%h count=%0d want 0055 1",
               bus.FifoPreOut, bus.Count);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_fill_ovf();
    test_push_pop_full();
    test_underflow_clean();
    test_squash();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
